logic_op_arbiter: RTL
=====================

# logic_op_arbiter

Shares one bitwise/logical operation unit among `NREQ` requesters. Each requester submits an opcode and two operands through a valid/ready handshake. A round-robin arbiter grants one request per cycle. The result is registered into a single-entry output stage tagged with the requester index. The block sits between the control units that issue boolean operations and the shared logic datapath.

## Interface
- `NREQ`, 4, number of requesters (2..16)
- `W`, 2, operand/result width in bits (1..32)
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `req_valid` in NREQ: request pending, one bit per requester
- `req_ready` out NREQ: one-hot grant; a request is accepted when valid&ready
- `req_op` in 4*NREQ: opcode of requester i, bits [4i+3:4i]
- `req_a` in W*NREQ: operand A of requester i
- `req_b` in W*NREQ: operand B of requester i
- `rsp_valid` out 1: result held in output register
- `rsp_ready` in 1: consumer accepts result
- `rsp_id` out clog2(NREQ): index of the requester that produced the result
- `rsp_y` out W: result
- `rsp_err` out 1: opcode was illegal or not compiled in

## Operation
Opcode semantics (result width W):
- 0 AND: a&b
- 1 OR: a|b
- 2 NAND: ~(a&b)
- 3 NOR: ~(a|b)
- 4 XOR: a^b
- 5 XNOR: ~(a^b)
- 6 NOT: ~a
- 7 BUF: a
- 8 LAND: {W-1 zeros, (|a)&&(|b)}
- 9 LOR: {W-1 zeros, (|a)||(|b)}
- 10..15 illegal: y=0, err=1

Output stage is a two-state FSM:
- EMPTY: `rsp_valid`=0.
- FULL: `rsp_valid`=1.
- EMPTY→FULL on a grant.
- FULL→EMPTY on `rsp_ready` with no grant.
- FULL→FULL on `rsp_ready` with a grant; the register is reloaded.

Arbitration:
- Grants are allowed in a cycle iff state is EMPTY or `rsp_ready`=1.
- The winner is the first i with `req_valid[i]`, searching from pointer `ptr` upward, modulo NREQ.
- `req_ready` is combinational, is at most one-hot, and is 0 whenever grants are not allowed.
- On a grant to index g: `ptr` ← (g+1) mod NREQ, and `rsp_id`/`rsp_y`/`rsp_err` load next edge.
- Without a grant, `ptr` holds.
- While FULL and `rsp_ready`=0, `rsp_id`/`rsp_y`/`rsp_err` stay stable.
- Requesters may drop `req_valid` without acceptance; the arbiter does not lock.

## Timing
- Reset values: `rsp_valid`=0, `rsp_y`=0, `rsp_id`=0, `rsp_err`=0, `ptr`=0, state EMPTY.
- Asserting `rst` mid-operation discards a held result, with no response emitted.
- `req_ready` is 0 during any cycle with `rst`=1.
- Latency: acceptance at edge N → `rsp_valid`=1 with result after edge N, visible in cycle N+1.
- Throughput: one result per cycle while `rsp_ready`=1.
- Simultaneous drain and grant in one cycle: the result is replaced with no bubble.
- Fairness: a continuously valid requester is granted within NREQ grants.
- Combinational path from `req_valid`/`rsp_ready` to `req_ready`. No combinational path from `req_*` to `rsp_*`.

## Configuration
- `LOGIC_ARB_LOGICAL_OPS_EN` defined: opcodes 8/9 are implemented as above with `rsp_err`=0.
- Macro not defined: opcodes 8/9 are treated as illegal (y=0, err=1), and the reduction/logical logic is not synthesized.

## Structure
- Package `logic_arb_pkg`:
  - 4-bit opcode enum `logic_op_e` (values 0..9 named as above)
  - constant `LOGIC_OP_W`=4
- Sub-module `logic_op_alu`: purely combinational. Inputs op, a, b; outputs y, err. Parameterised by W and guarded by the macro.
- The arbiter, pointer and output FSM live in `logic_op_arbiter`.

## Test plan
- **Reset:** reset asserted with all `req_valid`=1 → `req_ready`=0, `rsp_valid`=0, `rsp_y`=0. After release, the first grant goes to requester 0.
- **Opcode sweep:** requester 2 only, a=2'b10, b=2'b11, opcodes 0..7.
  - Expected y = 10, 11, 01, 00, 01, 10, 01, 10, each with err=0 and `rsp_id`=2.
- **Logical ops and illegal opcodes:** a=0, b=2'b01.
  - With the macro: op 8 → y=00, op 9 → y=01.
  - Without the macro: both give y=0, err=1.
  - Op 12 always gives y=0, err=1.
- **Round-robin:** all 4 requesters valid continuously with `rsp_ready`=1 → `rsp_id` sequence 0,1,2,3,0,1 with one result per cycle.
- **Backpressure:** `rsp_ready`=0 for 5 cycles with requesters 1 and 3 valid.
  - Exactly one result is held stable and `req_ready`=0 throughout.
  - On `rsp_ready`=1, results stream in order 1, 3 with no bubble.
- **Reset mid-operation:** `rsp_valid`=1 and `rsp_ready`=0, then `rst` for 1 cycle → `rsp_valid`=0 the next cycle and `ptr` returns to 0.

Source files
------------

// File: rtl/logic_arb_pkg.sv
// logic_arb_pkg: opcode encoding shared by the logic-op arbiter and its ALU.
`default_nettype none

package logic_arb_pkg;

  localparam int LOGIC_OP_W = 4;

  typedef enum logic [LOGIC_OP_W-1:0] {
    OP_AND  = 4'd0,
    OP_OR   = 4'd1,
    OP_NAND = 4'd2,
    OP_NOR  = 4'd3,
    OP_XOR  = 4'd4,
    OP_XNOR = 4'd5,
    OP_NOT  = 4'd6,
    OP_BUF  = 4'd7,
    OP_LAND = 4'd8,
    OP_LOR  = 4'd9
  } logic_op_e;

endpackage

`default_nettype wire

// File: rtl/logic_op_alu.sv
// logic_op_alu: combinational bitwise/logical unit.
// Opcodes 8/9 exist only when LOGIC_ARB_LOGICAL_OPS_EN is defined.
`default_nettype none

module logic_op_alu
  import logic_arb_pkg::*;
#(
  parameter int W = 2
) (
  input  logic [LOGIC_OP_W-1:0] op,
  input  logic [W-1:0]          a,
  input  logic [W-1:0]          b,
  output logic [W-1:0]          y,
  output logic                  err
);

  always_comb begin
    y   = '0;
    err = 1'b0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_NOT:  y = ~a;
      OP_BUF:  y = a;
`ifdef LOGIC_ARB_LOGICAL_OPS_EN
      OP_LAND: y[0] = (|a) && (|b);
      OP_LOR:  y[0] = (|a) || (|b);
`endif
      default: err = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/logic_op_arbiter.sv
// logic_op_arbiter: round-robin sharing of one logic_op_alu among NREQ requesters,
// result held in a single-entry tagged output stage. Option: LOGIC_ARB_LOGICAL_OPS_EN.
`default_nettype none

module logic_op_arbiter
  import logic_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 2,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [LOGIC_OP_W*NREQ-1:0] req_op,
  input  logic [W*NREQ-1:0]          req_a,
  input  logic [W*NREQ-1:0]          req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [IDW-1:0]             rsp_id,
  output logic [W-1:0]               rsp_y,
  output logic                       rsp_err
);

  localparam logic           ST_EMPTY = 1'b0;
  localparam logic           ST_FULL  = 1'b1;
  localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);

  logic                  state, state_nxt;
  logic [IDW-1:0]        ptr;
  logic [NREQ-1:0]       rot;
  logic [IDW:0]          sum;
  logic                  found;
  logic [IDW-1:0]        win_idx;
  logic                  allowed;
  logic                  grant;
  logic [LOGIC_OP_W-1:0] sel_op;
  logic [W-1:0]          sel_a, sel_b;
  logic [W-1:0]          alu_y;
  logic                  alu_err;

  assign allowed = !rst && (state == ST_EMPTY || rsp_ready);

  // Rotate valids so bit 0 is the requester at ptr; first set bit wins.
  always_comb begin
    rot   = NREQ'({req_valid, req_valid} >> ptr);
    found = 1'b0;
    sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + (IDW+1)'(k);
      end
    end
    if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
    win_idx = sum[IDW-1:0];
  end

  always_comb begin
    req_ready = '0;
    sel_op    = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IDW'(i)) begin
        req_ready[i] = allowed && found;
        sel_op       = req_op[LOGIC_OP_W*i +: LOGIC_OP_W];
        sel_a        = req_a[W*i +: W];
        sel_b        = req_b[W*i +: W];
      end
    end
  end

  assign grant = |req_ready;

  logic_op_alu #(.W(W)) u_alu (
    .op  (sel_op),
    .a   (sel_a),
    .b   (sel_b),
    .y   (alu_y),
    .err (alu_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (grant) state_nxt = ST_FULL;
      ST_FULL:  if (rsp_ready && !grant) state_nxt = ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  always_comb begin
    rsp_valid = (state == ST_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      rsp_id  <= '0;
      rsp_y   <= '0;
      rsp_err <= 1'b0;
    end else if (grant) begin
      ptr     <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
      rsp_id  <= win_idx;
      rsp_y   <= alu_y;
      rsp_err <= alu_err;
    end
  end

endmodule

`default_nettype wire
